multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: Moore FSM plus ALU decode.
// Ports: clk, reset (async, high) | op, funct, zero in | write enables, mux selects, alucont, state out.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucont,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] st;
  logic [3:0] nxt;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       irw_m;
  logic       memw_m;
  logic       regw_m;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= FETCH;
    else       st <= nxt;
  end

  // Next-state logic; unused codes 12-15 fall back to FETCH
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // Moore outputs
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = 2'b00;
    irw_m    = 1'b0;
    memw_m   = 1'b0;
    regw_m   = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    case (st)
      FETCH: begin
        irw_m   = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regw_m   = 1'b1;
      end
      MEMWR: begin
        iord   = 1'b1;
        memw_m = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst = 1'b1;
        regw_m = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: regw_m = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are held off while reset is asserted, even though
  // the state already reads FETCH.
  assign irwrite  = irw_m  & ~reset;
  assign memwrite = memw_m & ~reset;
  assign regwrite = regw_m & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state    = st;

  // ALU control decode
  always_comb begin
    alucont = 3'b010;
    case (aluop)
      2'b01: alucont = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default:   alucont = 3'b010;
        endcase
      end
      default: alucont = 3'b010;
    endcase
  end

endmodule
